// File: rtl/seq2_feeder_pkg.sv
// Shared Seq2 opcode encodings and the feeder FSM state encodings.
package seq2_feeder_pkg;

  localparam int SEQ2_OPC_W = 4;

  localparam logic [SEQ2_OPC_W-1:0] SEQ2_NO = 4'h0;
  localparam logic [SEQ2_OPC_W-1:0] SEQ2_CI = 4'h1;
  localparam logic [SEQ2_OPC_W-1:0] SEQ2_CR = 4'h2;
  localparam logic [SEQ2_OPC_W-1:0] SEQ2_JI = 4'h3;
  localparam logic [SEQ2_OPC_W-1:0] SEQ2_JR = 4'h4;
  localparam logic [SEQ2_OPC_W-1:0] SEQ2_JZ = 4'h5;
  localparam logic [SEQ2_OPC_W-1:0] SEQ2_WN = 4'h6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_BREAK = 3'd3,
    ST_DONE  = 3'd4,
    ST_STALL = 3'd5
  } feeder_state_e;

endpackage

// File: rtl/seq2_feeder_mem.sv
// Program store: synchronous write port, asynchronous read port, contents not reset.
module seq2_feeder_mem #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 20
) (
  input  logic              clock,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wen) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/seq2_feeder.sv
// Instruction-issuing end of the Seq2 interface: program store lookup on Seq2's next address,
// run/step/stop control, breakpoint, self-jump completion and stall watchdog.
module seq2_feeder
  import seq2_feeder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int INST_W = 20,
  parameter int WDOG   = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [INST_W-1:0] load_data,
  input  logic              load_wen,
  input  logic              start,
  input  logic              step,
  input  logic              stop,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] next,
  output logic [INST_W-1:0] inst,
  output logic              inst_en,
  output logic [2:0]        state_o,
  output logic [15:0]       icount
);

  localparam int OPC_MSB = INST_W - 1;
  localparam int TGT_MSB = INST_W - SEQ2_OPC_W - 1;

  feeder_state_e     state, state_nxt;
  logic [INST_W-1:0] rd_inst;
  logic              mem_wen;
  logic              self_jump;
  logic              bp_hit;
  logic              wdog_hit;
  logic              resume;
  logic [ADDR_W-1:0] prev_next;
  logic [15:0]       wdog;
  logic [15:0]       wdog_inc;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign mem_wen = load_wen && (state == ST_IDLE);

  seq2_feeder_mem #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_mem (
    .clock (clock),
    .wen   (mem_wen),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (next),
    .rdata (rd_inst)
  );

  // A JI whose target is its own address means the program has finished.
  assign self_jump = (rd_inst[OPC_MSB -: SEQ2_OPC_W] == SEQ2_JI) &&
                     (rd_inst[TGT_MSB -: ADDR_W] == next);
  assign bp_hit    = bp_en && (next == bp_addr) && !resume;
  assign wdog_inc  = (next == prev_next) ? sat_inc16(wdog) : 16'd0;
  assign wdog_hit  = (WDOG != 0) && (wdog_inc == 16'(WDOG));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_BREAK: begin
        if (stop)       state_nxt = ST_IDLE;
        else if (start) state_nxt = ST_RUN;
        else if (step)  state_nxt = ST_STEP;
      end
      ST_RUN: begin
        if (stop)           state_nxt = ST_IDLE;
        else if (bp_hit)    state_nxt = ST_BREAK;
        else if (self_jump) state_nxt = ST_DONE;
        else if (wdog_hit)  state_nxt = ST_STALL;
      end
      ST_STEP: begin
        if (stop)           state_nxt = ST_IDLE;
        else if (self_jump) state_nxt = ST_DONE;
        else                state_nxt = ST_BREAK;
      end
      default: begin
        if (stop) state_nxt = ST_IDLE;
      end
    endcase
  end

  // Zero-latency issue: Seq2 samples inst/inst_en at the same edge that follows next.
  always_comb begin
    inst_en = 1'b0;
    case (state)
      ST_RUN:  inst_en = !bp_hit && !self_jump;
      ST_STEP: inst_en = !self_jump;
      default: inst_en = 1'b0;
    endcase
    inst = inst_en ? rd_inst : {SEQ2_NO, {(INST_W-SEQ2_OPC_W){1'b0}}};
  end

  assign state_o = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_next <= '0;
      wdog      <= 16'd0;
      resume    <= 1'b0;
      icount    <= 16'd0;
    end else begin
      prev_next <= next;
      wdog      <= (state == ST_RUN && state_nxt == ST_RUN) ? wdog_inc : 16'd0;
      resume    <= (state == ST_BREAK) && (state_nxt == ST_RUN);
      if (state == ST_IDLE && (state_nxt == ST_RUN || state_nxt == ST_STEP))
        icount <= 16'd0;
      else if (inst_en)
        icount <= sat_inc16(icount);
    end
  end

endmodule

// File: tb/tb_seq2_feeder.sv
// Bench for seq2_feeder: a Seq2 stub follows issued instructions, a program-level model predicts
// the issued trace into a scoreboard queue, and an independent monitor checks every issue.
module tb_seq2_feeder;
  import seq2_feeder_pkg::*;

  localparam int ADDR_W = 8;
  localparam int INST_W = 20;
  localparam int WDOG   = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] load_addr, bp_addr, next;
  logic [INST_W-1:0] load_data, inst;
  logic              load_wen, start, step, stop, bp_en, inst_en;
  logic [2:0]        state_o;
  logic [15:0]       icount;

  int n_checks = 0;
  int n_fail   = 0;

  logic [INST_W-1:0] exp_q [$];
  logic [INST_W-1:0] shadow [256];
  int                wn_wait;   // WN cycles Seq2 still waits; -1 = never satisfied

  seq2_feeder #(.ADDR_W(ADDR_W), .INST_W(INST_W), .WDOG(WDOG)) dut (
    .clock(clock), .reset(reset), .load_addr(load_addr), .load_data(load_data),
    .load_wen(load_wen), .start(start), .step(step), .stop(stop), .bp_addr(bp_addr),
    .bp_en(bp_en), .next(next), .inst(inst), .inst_en(inst_en), .state_o(state_o),
    .icount(icount)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Seq2 behaviour as seen by the feeder: where next goes after an instruction is accepted.
  function automatic logic [7:0] seq2_advance(input logic [7:0] a, input logic [19:0] d,
                                              inout int w);
    if (d[19:16] == SEQ2_WN && w != 0) begin
      if (w > 0) w--;
      return a;
    end
    if (d[19:16] == SEQ2_JI) return d[15:8];
    return a + 8'd1;
  endfunction

  // Program-level prediction of one RUN segment starting at a0.
  task automatic predict_run(input logic [7:0] a0, input bit skip0,
                             output feeder_state_e st, output int n);
    logic [7:0]  a, prev;
    logic [19:0] d;
    int          w, unchanged;
    bit          skip;
    a = a0; prev = a0; w = wn_wait; unchanged = 0; skip = skip0; n = 0; st = ST_RUN;
    for (int c = 0; c < 1000; c++) begin
      unchanged = (a == prev) ? unchanged + 1 : 0;
      d = shadow[a];
      if (bp_en && a == bp_addr && !skip) begin st = ST_BREAK; return; end
      if (d[19:16] == SEQ2_JI && d[15:8] == a) begin st = ST_DONE; return; end
      exp_q.push_back(d);
      n++;
      if (WDOG != 0 && unchanged == WDOG) begin st = ST_STALL; return; end
      prev = a;
      a = seq2_advance(a, d, w);
      skip = 1'b0;
    end
  endtask

  task automatic cycle();
    logic        e;
    logic [19:0] d;
    @(negedge clock);
    e = inst_en;
    d = inst;
    @(posedge clock);
    #1;
    if (e) next = seq2_advance(next, d, wn_wait);
  endtask

  task automatic load(input logic [7:0] a, input logic [19:0] d);
    load_addr = a; load_data = d; load_wen = 1'b1;
    shadow[a] = d;
    cycle();
    load_wen = 1'b0;
  endtask

  task automatic run_until_settled(input string name);
    int c;
    c = 0;
    while ((state_o == ST_RUN || state_o == ST_STEP) && c < 400) begin
      cycle();
      c++;
    end
    check({name, "_settle"}, (c < 400), 1);
  endtask

  task automatic do_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic do_stop(input string name);
    stop = 1'b1; cycle(); stop = 1'b0;
    check({name, "_idle"}, state_o, ST_IDLE);
  endtask

  initial begin : monitor
    logic [19:0] e;
    forever begin
      @(negedge clock);
      if (reset && inst_en) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL issue: got inst %0h, required no issue", inst);
        end else begin
          e = exp_q.pop_front();
          if (inst !== e) begin
            n_fail++;
            $display("FAIL issue: got inst %0h, required %0h", inst, e);
          end
        end
      end
    end
  end

  initial begin : stim
    feeder_state_e est;
    int            n, total;
    logic [3:0]    ops [4];
    ops = '{SEQ2_CI, SEQ2_CR, SEQ2_JR, SEQ2_JZ};

    reset = 1'b0; next = '0; load_addr = '0; load_data = '0; load_wen = 1'b0;
    start = 1'b0; step = 1'b0; stop = 1'b0; bp_addr = '0; bp_en = 1'b0; wn_wait = 0;
    #1;
    check("rst_state", state_o, ST_IDLE);
    check("rst_inst_en", inst_en, 0);
    check("rst_inst", inst, {SEQ2_NO, 16'h0});
    check("rst_icount", icount, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // 1: two issues then self-jump; last word loaded together with start
    load(8'h00, {SEQ2_CI, 16'h1234});
    load(8'h01, {SEQ2_JI, 8'h05, 8'h00});
    next = 8'h00;
    shadow[5] = {SEQ2_JI, 8'h05, 8'h00};
    predict_run(8'h00, 1'b0, est, n);
    load_addr = 8'h05; load_data = {SEQ2_JI, 8'h05, 8'h00}; load_wen = 1'b1; start = 1'b1;
    cycle();
    load_wen = 1'b0; start = 1'b0;
    run_until_settled("t1");
    check("t1_state", state_o, ST_DONE);
    check("t1_icount", icount, 16'(n));
    check("t1_inst_en", inst_en, 0);
    do_stop("t1");

    // 2: breakpoint, step over it, resume
    next = 8'h00; bp_en = 1'b1; bp_addr = 8'h01;
    predict_run(8'h00, 1'b0, est, n);
    do_start();
    run_until_settled("t2a");
    check("t2_break", state_o, ST_BREAK);
    check("t2_break_inst_en", inst_en, 0);
    exp_q.push_back(shadow[1]);
    step = 1'b1; cycle(); step = 1'b0;
    cycle();
    check("t2_step_break", state_o, ST_BREAK);
    predict_run(next, 1'b1, est, n);
    do_start();
    run_until_settled("t2b");
    check("t2_done", state_o, ST_DONE);
    check("t2_icount", icount, 2);
    do_stop("t2");
    bp_en = 1'b0;

    // 3: WN held for 10 waiting cycles, then advances to completion
    load(8'h30, {SEQ2_WN, 14'h0, 2'b01});
    load(8'h31, {SEQ2_JI, 8'h31, 8'h00});
    next = 8'h30; wn_wait = 10;
    predict_run(8'h30, 1'b0, est, n);
    do_start();
    run_until_settled("t3");
    check("t3_state", state_o, est);
    check("t3_icount", icount, 11);
    do_stop("t3");

    // 4: WN never satisfied -> watchdog stall
    load(8'h40, {SEQ2_WN, 14'h0, 2'b01});
    next = 8'h40; wn_wait = -1;
    predict_run(8'h40, 1'b0, est, n);
    do_start();
    run_until_settled("t4");
    check("t4_stall", state_o, ST_STALL);
    check("t4_inst_en", inst_en, 0);
    check("t4_icount", icount, WDOG);
    do_stop("t4");

    // 5: load during RUN ignored; stop+start together stays IDLE; readback by step
    load(8'h10, {SEQ2_CI, 16'hAAAA});
    next = 8'h40; wn_wait = -1;
    repeat (3) exp_q.push_back(shadow[8'h40]);
    do_start();
    load_addr = 8'h10; load_data = {SEQ2_CR, 16'hBBBB}; load_wen = 1'b1;
    cycle();
    load_wen = 1'b0;
    cycle();
    stop = 1'b1; cycle(); stop = 1'b0;
    check("t5_stop_idle", state_o, ST_IDLE);
    check("t5_icount", icount, 3);
    stop = 1'b1; start = 1'b1; cycle(); stop = 1'b0; start = 1'b0;
    check("t5_stopstart_idle", state_o, ST_IDLE);
    check("t5_icount_kept", icount, 3);
    next = 8'h10; wn_wait = 0;
    exp_q.push_back(shadow[8'h10]);
    step = 1'b1; cycle(); step = 1'b0;
    cycle();
    check("t5_step_break", state_o, ST_BREAK);
    check("t5_step_icount", icount, 1);
    do_stop("t5");

    // 6: asynchronous reset mid-RUN, program store retained
    next = 8'h40; wn_wait = -1;
    repeat (2) exp_q.push_back(shadow[8'h40]);
    do_start();
    cycle();
    cycle();
    #2 reset = 1'b0;
    #1;
    check("t6_inst_en", inst_en, 0);
    check("t6_inst", inst, {SEQ2_NO, 16'h0});
    check("t6_state", state_o, ST_IDLE);
    check("t6_icount", icount, 0);
    cycle();
    cycle();
    reset = 1'b1;
    next = 8'h00; wn_wait = 0;
    predict_run(8'h00, 1'b0, est, n);
    do_start();
    run_until_settled("t6");
    check("t6_rerun_done", state_o, ST_DONE);
    check("t6_rerun_icount", icount, 2);
    do_stop("t6");

    // randomized straight-line programs ending in a self-jump, optional breakpoint
    for (int it = 0; it < 8; it++) begin
      logic [7:0] base;
      int         len, seg;
      base = 8'h80 + 8'($urandom_range(0, 63));
      len  = $urandom_range(1, 10);
      for (int k = 0; k < len; k++)
        load(base + 8'(k), {ops[$urandom_range(0, 3)], 16'($urandom)});
      load(base + 8'(len), {SEQ2_JI, base + 8'(len), 8'($urandom)});
      bp_en   = 1'($urandom_range(0, 1));
      bp_addr = base + 8'($urandom_range(0, len));
      next = base; wn_wait = 0;
      predict_run(base, 1'b0, est, n);
      total = n;
      do_start();
      run_until_settled("rnd");
      seg = 0;
      while (est == ST_BREAK && seg < 3) begin
        check("rnd_break", state_o, ST_BREAK);
        check("rnd_break_icount", icount, 16'(total));
        predict_run(next, 1'b1, est, n);
        total += n;
        do_start();
        run_until_settled("rnd_resume");
        seg++;
      end
      check("rnd_final_state", state_o, est);
      check("rnd_icount", icount, 16'(total));
      do_stop("rnd");
      bp_en = 1'b0;
    end

    cycle();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
